insulin_pump_controller: RTL



---
 rtl/insulin_pump_controller_pkg.sv | 9 +
 rtl/insulin_pump_controller_gi_window_accumulator.sv | 33 +++
 rtl/insulin_pump_controller.sv | 77 +++++++
 3 files changed

// File: rtl/insulin_pump_controller_pkg.sv
// insulin_pump_controller_pkg: shared states, widths and default thresholds for the insulin pump controller
package insulin_pump_controller_pkg;
    localparam int GI_W                = 4;
    localparam int DOSE_W              = 3;
    localparam int DEF_CYCLES_PER_UNIT = 4;
    localparam int DEF_HIGH_THRESH     = 6;
    localparam int DEF_LOW_THRESH      = 2;
    typedef enum logic [1:0] {COLLECT, DECIDE, INJECT} state_e;
endpackage

// File: rtl/insulin_pump_controller_gi_window_accumulator.sv
// gi_window_accumulator: sums a window of four glycemic index samples and exposes their truncated average
module gi_window_accumulator
    import insulin_pump_controller_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            accept,
    input  logic            clear,
    input  logic [GI_W-1:0] sample,
    output logic            window_full,
    output logic [GI_W-1:0] avg
);
    logic [5:0] sum_q, sum_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        sum_d   = clear ? '0 : accept ? sum_q + 6'(sample) : sum_q;
        count_d = clear ? '0 : accept ? count_q + 2'd1 : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    assign window_full = accept && count_q == 2'd3;
    assign avg         = sum_q[5:2];
endmodule

// File: rtl/insulin_pump_controller.sv
// insulin_pump_controller: averages four glycemic index samples, decides a dose or low alarm, and times the pump
module insulin_pump_controller
    import insulin_pump_controller_pkg::*;
#(
    parameter int CYCLES_PER_UNIT = DEF_CYCLES_PER_UNIT,
    parameter int HIGH_THRESH     = DEF_HIGH_THRESH,
    parameter int LOW_THRESH      = DEF_LOW_THRESH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gi_valid,
    input  logic [GI_W-1:0]   glycemic_index,
    output logic              gi_ready,
    output logic              pump_on,
    output logic [DOSE_W-1:0] dose_units,
    output logic              alarm_low,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [6:0]        timer_q, timer_d;
    logic [DOSE_W-1:0] dose_q, dose_d, dose_calc;
    logic              alarm_q, alarm_d;
    logic              window_full;
    logic [GI_W-1:0]   avg;
    logic [GI_W:0]     over;

    gi_window_accumulator u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept      (gi_valid && gi_ready),
        .clear       (state_q == DECIDE),
        .sample      (glycemic_index),
        .window_full (window_full),
        .avg         (avg)
    );

    always_comb begin
        over      = {1'b0, avg} - 5'(HIGH_THRESH) + 5'd1;
        dose_calc = avg < 4'(HIGH_THRESH) ? '0 : (over > 5'd7 ? 3'd7 : over[2:0]);
        state_d   = state_q;
        timer_d   = timer_q;
        dose_d    = dose_q;
        alarm_d   = alarm_q;
        if (state_q == COLLECT) begin
            state_d = window_full ? DECIDE : COLLECT;
        end else if (state_q == DECIDE) begin
            dose_d  = dose_calc;
            alarm_d = avg <= 4'(LOW_THRESH);
            state_d = dose_calc != '0 ? INJECT : COLLECT;
            timer_d = 7'(dose_calc) * 7'(CYCLES_PER_UNIT) - 7'd1;
        end else begin
            // the timer holds remaining pump cycles minus one, so the exit edge sees zero
            timer_d = timer_q - 7'd1;
            state_d = timer_q == '0 ? COLLECT : INJECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            timer_q <= '0;
            dose_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dose_q  <= dose_d;
            alarm_q <= alarm_d;
        end
    end

    assign gi_ready   = state_q == COLLECT;
    assign pump_on    = state_q == INJECT;
    assign busy       = state_q != COLLECT;
    assign dose_units = dose_q;
    assign alarm_low  = alarm_q;
endmodule
